// File: rtl/half_sub.sv
// half_sub: per-lane half-subtractor (d = a ^ b, bo = ~a & b) behind a
// LATENCY-deep valid-qualified register pipeline. Lanes are independent.
module half_sub #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] bo
);

    localparam int unsigned LAST = LATENCY - 1;

    // Per-stage payload: difference and borrow lanes
    typedef struct packed {
        logic [WIDTH-1:0] dif;
        logic [WIDTH-1:0] bor;
    } lane_t;

    lane_t [LATENCY-1:0] stg_q, stg_d;
    logic  [LATENCY-1:0] vld_q, vld_d;

    // Next-stage values: capture upstream only when upstream is valid, else hold data and bubble
    always_comb begin
        stg_d    = stg_q;
        vld_d    = '0;
        vld_d[0] = in_valid;
        if (in_valid) begin
            stg_d[0].dif = a ^ b;
            stg_d[0].bor = ~a & b;
        end
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                stg_d[i] = stg_q[i-1];
            end
        end
    end

    // Stage registers with synchronous reset that flushes data and valids
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q <= '0;
            vld_q <= '0;
        end else begin
            stg_q <= stg_d;
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign d         = stg_q[LAST].dif;
    assign bo        = stg_q[LAST].bor;

endmodule

// File: tb/tb_half_sub.sv
// Bench for half_sub: three configurations (W1/L1, W4/L3, W8/L2) checked every
// cycle against a history-based reference model, plus hand-computed literals.
module tb_half_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       iv1 = 1'b0, iv4 = 1'b0, iv8 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] a8 = '0, b8 = '0;

    logic       ov1, ov4, ov8;
    logic [0:0] d1, bo1;
    logic [3:0] d4, bo4;
    logic [7:0] d8, bo8;

    half_sub #(.WIDTH(1), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1),
        .out_valid(ov1), .d(d1), .bo(bo1));
    half_sub #(.WIDTH(4), .LATENCY(3)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4),
        .out_valid(ov4), .d(d4), .bo(bo4));
    half_sub #(.WIDTH(8), .LATENCY(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8),
        .out_valid(ov8), .d(d8), .bo(bo8));

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: output after edge k is the operand sampled at edge k-L+1,
    // unless a reset landed anywhere in that window (then everything is zero).
    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [7:0] a;
        logic [7:0] b;
    } smp_t;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [7:0] bo;
    } res_t;

    smp_t h1[$], h4[$], h8[$];
    res_t e1 = '0, e4 = '0, e8 = '0;
    bit   started = 1'b0;

    function automatic res_t predict(input smp_t h[$], input int lat, input res_t prev,
                                     input logic [7:0] mask);
        res_t r;
        smp_t s;
        for (int i = 0; i < lat; i++) begin
            if (h[i].rst) return '0;
        end
        s = h[lat-1];
        if (s.iv) begin
            r.v  = 1'b1;
            r.d  = (s.a ^ s.b) & mask;
            r.bo = (~s.a & s.b) & mask;
        end else begin
            r.v  = 1'b0;
            r.d  = prev.d;
            r.bo = prev.bo;
        end
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            h1.push_front('{1'b1, 1'b0, 8'h00, 8'h00});
            h4.push_front('{1'b1, 1'b0, 8'h00, 8'h00});
            h8.push_front('{1'b1, 1'b0, 8'h00, 8'h00});
        end
    end

    // Model update on every rising edge from the sampled inputs
    always @(posedge clk) begin
        h1.push_front('{rst, iv1, 8'(a1), 8'(b1)});
        h4.push_front('{rst, iv4, 8'(a4), 8'(b4)});
        h8.push_front('{rst, iv8, 8'(a8), 8'(b8)});
        if (h1.size() > 4) void'(h1.pop_back());
        if (h4.size() > 4) void'(h4.pop_back());
        if (h8.size() > 4) void'(h8.pop_back());
        e1 = predict(h1, 1, e1, 8'h01);
        e4 = predict(h4, 3, e4, 8'h0F);
        e8 = predict(h8, 2, e8, 8'hFF);
        started = 1'b1;
    end

    // Compare every cycle, away from the rising edge
    always @(negedge clk) begin
        if (started) begin
            check("m1.v",  32'(ov1), 32'(e1.v));
            check("m1.d",  32'(d1),  32'(e1.d));
            check("m1.bo", 32'(bo1), 32'(e1.bo));
            check("m4.v",  32'(ov4), 32'(e4.v));
            check("m4.d",  32'(d4),  32'(e4.d));
            check("m4.bo", 32'(bo4), 32'(e4.bo));
            check("m8.v",  32'(ov8), 32'(e8.v));
            check("m8.d",  32'(d8),  32'(e8.d));
            check("m8.bo", 32'(bo8), 32'(e8.bo));
        end
    end

    task automatic lit4(input string name, input logic v, input logic [3:0] ed, input logic [3:0] eb);
        check({name, ".v"},  32'(ov4), 32'(v));
        check({name, ".d"},  32'(d4),  32'(ed));
        check({name, ".bo"}, 32'(bo4), 32'(eb));
    endtask

    task automatic all_zero(input string name);
        check({name, ".ov"}, 32'({ov1, ov4, ov8}), 32'd0);
        check({name, ".d"},  32'({d1, d4, d8}),    32'd0);
        check({name, ".bo"}, 32'({bo1, bo4, bo8}), 32'd0);
    endtask

    logic [1:0] tt_ab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] tt_db [4] = '{2'b00, 2'b11, 2'b10, 2'b00};

    initial begin
        // Reset held 3 cycles with valid operands that must be discarded
        rst = 1'b1;
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'h0;
        iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        repeat (3) begin
            @(negedge clk);
            all_zero("rst_hold");
        end
        rst = 1'b0; iv1 = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            all_zero("rst_release");
        end

        // Truth table on the single-lane, single-cycle instance
        {a1, b1} = tt_ab[0]; iv1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("tt.v",  32'(ov1), 32'd1);
            check("tt.d",  32'(d1),  32'(tt_db[i][1]));
            check("tt.bo", 32'(bo1), 32'(tt_db[i][0]));
            if (i < 3) {a1, b1} = tt_ab[i+1];
            else       iv1 = 1'b0;
        end

        // Multi-lane on the 4-lane, 3-cycle instance
        iv4 = 1'b1; a4 = 4'b0011; b4 = 4'b0101;
        @(negedge clk); iv4 = 1'b0;
        @(negedge clk);
        @(negedge clk); lit4("lanes", 1'b1, 4'b0110, 4'b0100);

        // valid / idle / valid pattern must reappear 3 cycles later
        @(negedge clk); lit4("lanes_hold", 1'b0, 4'b0110, 4'b0100);
        iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b0000;
        @(negedge clk); iv4 = 1'b0;
        @(negedge clk); iv4 = 1'b1; a4 = 4'b0000; b4 = 4'b0110;
        @(negedge clk); iv4 = 1'b0;
        lit4("bub0", 1'b1, 4'b1111, 4'b0000);
        @(negedge clk); lit4("bub1", 1'b0, 4'b1111, 4'b0000);
        @(negedge clk); lit4("bub2", 1'b1, 4'b0110, 4'b0110);

        // Reset pulse with two results in flight: both flushed
        iv4 = 1'b1; a4 = 4'b1010; b4 = 4'b1100;
        @(negedge clk); a4 = 4'b0101; b4 = 4'b0011;
        @(negedge clk); iv4 = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            lit4("flush", 1'b0, 4'b0000, 4'b0000);
        end
        iv4 = 1'b1; a4 = 4'b0001; b4 = 4'b0010;
        @(negedge clk); iv4 = 1'b0; lit4("post_rst0", 1'b0, 4'b0000, 4'b0000);
        @(negedge clk); lit4("post_rst1", 1'b0, 4'b0000, 4'b0000);
        @(negedge clk); lit4("post_rst2", 1'b1, 4'b0011, 4'b0010);

        // Random traffic on all instances with occasional resets
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 63) == 0);
            iv1 = 1'($urandom_range(0, 1)); a1 = 1'($urandom); b1 = 1'($urandom);
            iv4 = 1'($urandom_range(0, 1)); a4 = 4'($urandom); b4 = 4'($urandom);
            iv8 = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; iv1 = 1'b0; iv4 = 1'b0; iv8 = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
